// File: rtl/truth_table_sweeper.sv
// Sweeps x through 0..2^N-1 one row per clock and records f(x) = ~(^x & &x); done 2^N+1 cycles after start.
// No backpressure: start is only taken in IDLE and is dropped otherwise. `SWEEPER_CHECK_EN adds a golden-table compare.
module truth_table_sweeper #(
   parameter int N = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [N-1:0]         x,
   output logic                 f,
   output logic [(1<<N)-1:0]    table_out,
   output logic [N:0]           ones_count
`ifdef SWEEPER_CHECK_EN
   ,
   input  logic [(1<<N)-1:0]    expected,
   output logic                 pass,
   output logic [N-1:0]         first_fail
`endif
);

   localparam logic [N-1:0] LAST_ROW = {N{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

   state_t       state;
   logic [N-1:0] idx;

   // idx is forced back to zero outside SWEEP, so x is 0 in IDLE and DONE
   assign x = idx;
   assign f = ~((^x) & (&x));

`ifdef SWEEPER_CHECK_EN
   logic fail;
   logic mismatch;

   assign mismatch = f ^ expected[idx];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fail       <= 1'b0;
         pass       <= 1'b0;
         first_fail <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  fail       <= 1'b0;
                  pass       <= 1'b0;
                  first_fail <= '0;
               end
            end
            S_SWEEP: begin
               if (mismatch && !fail) begin
                  fail       <= 1'b1;
                  first_fail <= idx;
               end
               // the last row's own mismatch must count toward the verdict
               if (idx == LAST_ROW)
                  pass <= ~(fail | mismatch);
            end
            default: ;
         endcase
      end
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         idx        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         table_out  <= '0;
         ones_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_SWEEP;
                  busy       <= 1'b1;
                  idx        <= '0;
                  table_out  <= '0;
                  ones_count <= '0;
               end
            end
            S_SWEEP: begin
               table_out[idx] <= f;
               ones_count     <= ones_count + {{N{1'b0}}, f};
               if (idx == LAST_ROW) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  idx   <= '0;
               end else begin
                  idx <= idx + N'(1);
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: an N=2 and an N=3 sweeper driven with randomized timing and start noise,
// compared against a truth-table model computed from the expression itself.
module tb_truth_table_sweeper;

   logic       clock;
   logic       reset;
   logic       start2, start3;
   logic [7:0] exp_bus;

   logic       busy2, done2, f2, busy3, done3, f3;
   logic [1:0] x2;
   logic [2:0] x3;
   logic [3:0] tab2;
   logic [7:0] tab3;
   logic [2:0] ones2;
   logic [3:0] ones3;
`ifdef SWEEPER_CHECK_EN
   logic       pass2, pass3;
   logic [1:0] ff2;
   logic [2:0] ff3;
`endif

   int checks = 0;
   int errors = 0;

   truth_table_sweeper #(.N(2)) u2 (
      .clock(clock), .reset(reset), .start(start2),
      .busy(busy2), .done(done2), .x(x2), .f(f2),
      .table_out(tab2), .ones_count(ones2)
`ifdef SWEEPER_CHECK_EN
      , .expected(exp_bus[3:0]), .pass(pass2), .first_fail(ff2)
`endif
   );

   truth_table_sweeper #(.N(3)) u3 (
      .clock(clock), .reset(reset), .start(start3),
      .busy(busy3), .done(done3), .x(x3), .f(f3),
      .table_out(tab3), .ones_count(ones3)
`ifdef SWEEPER_CHECK_EN
      , .expected(exp_bus), .pass(pass3), .first_fail(ff3)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // f = NAND(XOR of all bits, AND of all bits), evaluated by counting set bits
   function automatic logic fref(input int n, input int i);
      int c = 0;
      for (int b = 0; b < n; b++) c += (i >> b) & 1;
      return !((c % 2 == 1) && (c == n));
   endfunction

   task automatic set_start(input int n, input logic v);
      if (n == 2) start2 = v; else start3 = v;
   endtask

   task automatic sample(input int n, output logic b, output logic d, output logic [7:0] xx,
                         output logic ff, output logic [7:0] tab, output logic [3:0] on,
                         output logic ps, output logic [7:0] fst);
      ps = 1'b0; fst = '0;
      if (n == 2) begin
         b = busy2; d = done2; xx = {6'b0, x2}; ff = f2; tab = {4'b0, tab2}; on = {1'b0, ones2};
`ifdef SWEEPER_CHECK_EN
         ps = pass2; fst = {6'b0, ff2};
`endif
      end else begin
         b = busy3; d = done3; xx = {5'b0, x3}; ff = f3; tab = tab3; on = ones3;
`ifdef SWEEPER_CHECK_EN
         ps = pass3; fst = {5'b0, ff3};
`endif
      end
   endtask

   task automatic test_reset;
      logic b, d, ff, ps; logic [7:0] xx, tab, fst; logic [3:0] on;
      reset = 1'b1; start2 = 1'b0; start3 = 1'b0; exp_bus = '0;
      #12;
      for (int n = 2; n <= 3; n++) begin
         sample(n, b, d, xx, ff, tab, on, ps, fst);
         checks++; if (b !== 1'b0 || d !== 1'b0) begin errors++; $display("FAIL reset_busy_done n=%0d got=%b%b want=00", n, b, d); end
         checks++; if (xx !== 8'd0 || ff !== 1'b1) begin errors++; $display("FAIL reset_x_f n=%0d got x=%h f=%b want x=0 f=1", n, xx, ff); end
         checks++; if (tab !== 8'd0 || on !== 4'd0) begin errors++; $display("FAIL reset_table n=%0d got tab=%h ones=%0d want 0 0", n, tab, on); end
         checks++; if (ps !== 1'b0 || fst !== 8'd0) begin errors++; $display("FAIL reset_check n=%0d got pass=%b ff=%0d want 0 0", n, ps, fst); end
      end
      #2 reset = 1'b0;
      @(posedge clock); #1;
   endtask

   // Called #1 after a rising edge with the DUT in IDLE; leaves it IDLE, #1 after an edge.
   task automatic run_sweep(input int n, input logic [7:0] exp, input bit noise);
      logic b, d, ff, ps; logic [7:0] xx, tab, fst; logic [3:0] on;
      int rows = 1 << n;
      logic [7:0] tab_m = '0;
      logic [3:0] ones_m = '0;
      int ff_m = -1;
      for (int i = 0; i < rows; i++) begin
         tab_m[i] = fref(n, i);
         ones_m += {3'b0, tab_m[i]};
         if (ff_m < 0 && exp[i] != tab_m[i]) ff_m = i;
      end
      exp_bus = exp;
      repeat ($urandom % 3) begin
         @(posedge clock); #1;
         sample(n, b, d, xx, ff, tab, on, ps, fst);
         checks++; if (b !== 1'b0) begin errors++; $display("FAIL idle_busy n=%0d got=%b want=0", n, b); end
      end
      set_start(n, 1'b1);
      @(posedge clock); #1;
      for (int i = 0; i < rows; i++) begin
         set_start(n, noise ? logic'($urandom % 2) : 1'b0);
         sample(n, b, d, xx, ff, tab, on, ps, fst);
         checks++; if (b !== 1'b1 || d !== 1'b0) begin errors++; $display("FAIL sweep_busy n=%0d row=%0d got busy=%b done=%b want 1 0", n, i, b, d); end
         checks++; if (xx !== 8'(i) || ff !== tab_m[i]) begin errors++; $display("FAIL sweep_row n=%0d row=%0d got x=%0d f=%b want x=%0d f=%b", n, i, xx, ff, i, tab_m[i]); end
`ifdef SWEEPER_CHECK_EN
         if (i == 0) begin
            checks++; if (ps !== 1'b0 || fst !== 8'd0) begin errors++; $display("FAIL start_clears n=%0d got pass=%b ff=%0d want 0 0", n, ps, fst); end
         end
`endif
         @(posedge clock); #1;
      end
      set_start(n, noise ? 1'b1 : 1'b0);
      sample(n, b, d, xx, ff, tab, on, ps, fst);
      checks++; if (d !== 1'b1 || b !== 1'b0 || xx !== 8'd0) begin errors++; $display("FAIL done_cycle n=%0d got done=%b busy=%b x=%0d want 1 0 0", n, d, b, xx); end
      checks++; if (tab !== tab_m || on !== ones_m) begin errors++; $display("FAIL table n=%0d got tab=%h ones=%0d want tab=%h ones=%0d", n, tab, on, tab_m, ones_m); end
`ifdef SWEEPER_CHECK_EN
      checks++; if (ps !== (ff_m < 0)) begin errors++; $display("FAIL pass n=%0d exp=%h got=%b want=%b", n, exp, ps, ff_m < 0); end
      if (ff_m >= 0) begin
         checks++; if (fst !== 8'(ff_m)) begin errors++; $display("FAIL first_fail n=%0d exp=%h got=%0d want=%0d", n, exp, fst, ff_m); end
      end
`endif
      @(posedge clock); #1;
      set_start(n, 1'b0);
      sample(n, b, d, xx, ff, tab, on, ps, fst);
      checks++; if (d !== 1'b0 || b !== 1'b0) begin errors++; $display("FAIL after_done n=%0d got done=%b busy=%b want 0 0", n, d, b); end
      @(posedge clock); #1;
      sample(n, b, d, xx, ff, tab, on, ps, fst);
      checks++; if (b !== 1'b0 || tab !== tab_m || on !== ones_m) begin errors++; $display("FAIL hold n=%0d got busy=%b tab=%h ones=%0d want 0 %h %0d", n, b, tab, on, tab_m, ones_m); end
`ifdef SWEEPER_CHECK_EN
      checks++; if (ps !== (ff_m < 0)) begin errors++; $display("FAIL pass_hold n=%0d got=%b want=%b", n, ps, ff_m < 0); end
`endif
   endtask

   task automatic test_sweep;
      run_sweep(2, 8'h0F, 1'b0);
      run_sweep(3, 8'h7F, 1'b0);
   endtask

   task automatic test_ignore_start;
      run_sweep(2, 8'h0F, 1'b1);
      run_sweep(3, 8'h7F, 1'b1);
   endtask

   // start held high: each sweep spans rows + DONE + one IDLE cycle before the next accept
   task automatic test_back_to_back;
      int period = 6;
      int dones = 0;
      set_start(2, 1'b1);
      for (int j = 0; j < 12; j++) begin
         @(posedge clock); #1;
         if (j == 11) set_start(2, 1'b0);
         checks++;
         if (busy2 !== ((j % period) < 4) || done2 !== ((j % period) == 4)) begin
            errors++; $display("FAIL back_to_back j=%0d got busy=%b done=%b want %b %b", j, busy2, done2, (j % period) < 4, (j % period) == 4);
         end
         if (done2 === 1'b1) dones++;
      end
      checks++; if (dones != 2) begin errors++; $display("FAIL back_to_back_dones got=%0d want=2", dones); end
      @(posedge clock); #1;
   endtask

   task automatic test_reset_mid_sweep;
      set_start(3, 1'b1);
      @(posedge clock); #1;
      set_start(3, 1'b0);
      repeat (4) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      checks++; if (busy3 !== 1'b0 || done3 !== 1'b0 || x3 !== 3'd0) begin errors++; $display("FAIL async_reset_ctl got busy=%b done=%b x=%0d want 0 0 0", busy3, done3, x3); end
      checks++; if (tab3 !== 8'd0 || ones3 !== 4'd0) begin errors++; $display("FAIL async_reset_table got tab=%h ones=%0d want 0 0", tab3, ones3); end
      #2 reset = 1'b0;
      @(posedge clock); #1;
      checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_idle got busy=%b want 0", busy3); end
      run_sweep(3, 8'h7F, 1'b0);
   endtask

`ifdef SWEEPER_CHECK_EN
   task automatic test_check;
      run_sweep(3, 8'h7F, 1'b0);
      run_sweep(3, 8'h7B, 1'b0);
      run_sweep(3, 8'hFF, 1'b0);
      repeat (4) run_sweep(3, ($urandom % 2) ? 8'h7F : 8'($urandom), 1'b0);
      run_sweep(2, 8'h07, 1'b0);
      run_sweep(2, 8'h0F, 1'b0);
   endtask
`endif

   initial begin
      test_reset;
      test_sweep;
      test_ignore_start;
      test_back_to_back;
      test_reset_mid_sweep;
`ifdef SWEEPER_CHECK_EN
      test_check;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
